// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbiter:
//   - arb_state_e      : arbiter FSM state encoding
//   - UART_CLOCK_RATE  : system clock rate the UART divider is built for
//   - DEF_*            : default arbiter parameters
//   - cnt_width/max3   : helpers for sizing saturating counters
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_CLOCK_RATE  = 12_000_000;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_GAP_CYCLES   = 16;
    localparam int DEF_BUSY_TIMEOUT = 64;
    localparam int DEF_LOCK_TIMEOUT = 120_000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } arb_state_e;

    // Bits needed to hold the value max_val (at least 1).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin find-first: returns the first asserted request
// found when searching upward from ptr_i, wrapping at NUM_REQ.
// Ports:
//   req_i   [NUM_REQ-1:0]        request vector
//   ptr_i   [$clog2(NUM_REQ)-1:0] search start index (must be < NUM_REQ)
//   valid_o                      any request asserted
//   idx_o   [$clog2(NUM_REQ)-1:0] index of the winner (0 when none)
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic                       valid_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // One extra bit so ptr + offset cannot overflow before the modulo fold.
    logic [IDX_W:0]   cand_sum [NUM_REQ];
    logic [IDX_W-1:0] cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand_sum[gi] = {1'b0, ptr_i} + (IDX_W+1)'(gi);
            assign cand_idx[gi] = (cand_sum[gi] >= (IDX_W+1)'(NUM_REQ))
                                ? IDX_W'(cand_sum[gi] - (IDX_W+1)'(NUM_REQ))
                                : IDX_W'(cand_sum[gi]);
            assign cand_hit[gi] = req_i[cand_idx[gi]];
        end
    endgenerate

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                valid_o = 1'b1;
                idx_o   = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin arbiter sharing one Uart8 transmitter between NUM_REQ byte
// producers. Sequences txStart -> txBusy -> txDone and supports locked
// multi-byte packets (reqLast=0 keeps the grant on the same requester).
// Ports:
//   clk_i, rstN_i              clock, asynchronous active-low reset
//   reqValid_i [NUM_REQ]       requester i has a byte
//   reqData_i  [8*NUM_REQ]     byte of requester i at [8i+7:8i]
//   reqLast_i  [NUM_REQ]       byte ends its packet (0 requests a lock)
//   reqReady_o [NUM_REQ]       one-cycle accept pulse
//   grantId_o                  current/last granted requester
//   locked_o                   packet lock held
//   errPulse_o                 one-cycle busy-timeout / lock-timeout pulse
//   txEn_o, txStart_o, txIn_o  UART tx controls
//   txBusy_i, txDone_i         UART status
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
    input  logic                       clk_i,
    input  logic                       rstN_i,
    input  logic [NUM_REQ-1:0]         reqValid_i,
    input  logic [8*NUM_REQ-1:0]       reqData_i,
    input  logic [NUM_REQ-1:0]         reqLast_i,
    output logic [NUM_REQ-1:0]         reqReady_o,
    output logic [$clog2(NUM_REQ)-1:0] grantId_o,
    output logic                       locked_o,
    output logic                       errPulse_o,
    output logic                       txEn_o,
    output logic                       txStart_o,
    output logic [7:0]                 txIn_o,
    input  logic                       txBusy_i,
    input  logic                       txDone_i
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int CNT_MAX = max3(GAP_CYCLES, BUSY_TIMEOUT, LOCK_TIMEOUT);
    localparam int CNT_W   = cnt_width(CNT_MAX);

    // Counter compares against limit-1: the counter reads 0 in the first
    // cycle of a state, so reaching N-1 means N cycles have elapsed.
    localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'((GAP_CYCLES   > 0) ? GAP_CYCLES   - 1 : 0);
    localparam logic [CNT_W-1:0] BUSY_LIM = CNT_W'((BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    arb_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic               have_grant_q, have_grant_d;
    logic               locked_q, locked_d;
    logic [7:0]         tx_in_q, tx_in_d;
    logic [NUM_REQ-1:0] ready_q, ready_d;
    logic               tx_start_q, tx_start_d;
    logic               err_q, err_d;
    logic               tx_en_q;

    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic               take;
    logic [IDX_W-1:0]   take_idx;

    // Search starts just past the last grant; before any grant, at 0.
    assign rr_ptr = !have_grant_q          ? '0 :
                    (grant_q == LAST_IDX)  ? '0 : grant_q + 1'b1;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_i   (reqValid_i),
        .ptr_i   (rr_ptr),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        grant_d      = grant_q;
        have_grant_d = have_grant_q;
        locked_d     = locked_q;
        tx_in_d      = tx_in_q;
        ready_d      = '0;
        tx_start_d   = 1'b0;
        err_d        = 1'b0;
        take         = 1'b0;
        take_idx     = grant_q;

        unique case (state_q)
            ST_IDLE: begin
                if (locked_q) begin
                    // Only the lock holder is eligible; the counter runs
                    // while it has nothing to send.
                    if (reqValid_i[grant_q]) begin
                        take = 1'b1;
                    end else if (cnt_q >= LOCK_LIM) begin
                        locked_d = 1'b0;
                        err_d    = 1'b1;
                    end
                end else if (pick_valid) begin
                    take     = 1'b1;
                    take_idx = pick_idx;
                end

                if (take) begin
                    grant_d           = take_idx;
                    have_grant_d      = 1'b1;
                    tx_in_d           = reqData_i[8*take_idx +: 8];
                    ready_d[take_idx] = 1'b1;
                    locked_d          = !reqLast_i[take_idx];
                    tx_start_d        = 1'b1;
                    state_d           = ST_START;
                end
            end

            ST_START: begin
                state_d = ST_WAIT_BUSY;
            end

            ST_WAIT_BUSY: begin
                if (txBusy_i) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q >= BUSY_LIM) begin
                    // Byte is dropped; the packet lock goes with it.
                    err_d    = 1'b1;
                    locked_d = 1'b0;
                    state_d  = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
            end

            ST_WAIT_DONE: begin
                if (txDone_i) begin
                    state_d = (locked_q || GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
            end

            ST_GAP: begin
                if (cnt_q >= GAP_LIM) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rstN_i) begin
        if (!rstN_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            grant_q      <= '0;
            have_grant_q <= 1'b0;
            locked_q     <= 1'b0;
            tx_in_q      <= '0;
            ready_q      <= '0;
            tx_start_q   <= 1'b0;
            err_q        <= 1'b0;
            tx_en_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            have_grant_q <= have_grant_d;
            locked_q     <= locked_d;
            tx_in_q      <= tx_in_d;
            ready_q      <= ready_d;
            tx_start_q   <= tx_start_d;
            err_q        <= err_d;
            tx_en_q      <= 1'b1;
        end
    end

    assign reqReady_o = ready_q;
    assign grantId_o  = grant_q;
    assign locked_o   = locked_q;
    assign errPulse_o = err_q;
    assign txEn_o     = tx_en_q;
    assign txStart_o  = tx_start_q;
    assign txIn_o     = tx_in_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter with a small Uart8 responder: busy rises
// with txStart, txDone pulses 4 cycles later. LOCK_TIMEOUT is shortened to 100.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rstN;
    logic [3:0]  reqValid;
    logic [31:0] reqData;
    logic [3:0]  reqLast;
    logic [3:0]  reqReady;
    logic [1:0]  grantId;
    logic        locked;
    logic        errPulse;
    logic        txEn;
    logic        txStart;
    logic [7:0]  txIn;
    logic        txBusy = 1'b0;
    logic        txDone = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int busy_cnt = 0;
    bit uart_mute;

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .GAP_CYCLES   (16),
        .BUSY_TIMEOUT (64),
        .LOCK_TIMEOUT (100)
    ) dut (
        .clk_i      (clk),
        .rstN_i     (rstN),
        .reqValid_i (reqValid),
        .reqData_i  (reqData),
        .reqLast_i  (reqLast),
        .reqReady_o (reqReady),
        .grantId_o  (grantId),
        .locked_o   (locked),
        .errPulse_o (errPulse),
        .txEn_o     (txEn),
        .txStart_o  (txStart),
        .txIn_o     (txIn),
        .txBusy_i   (txBusy),
        .txDone_i   (txDone)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // UART responder; it is not reset, like a Uart8 finishing its byte.
    always @(posedge clk) begin
        #1;
        txDone = 1'b0;
        if (txStart && !uart_mute) begin
            txBusy   = 1'b1;
            busy_cnt = 4;
        end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
            if (busy_cnt == 0) begin
                txBusy = 1'b0;
                txDone = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
        reqValid[i]      = v;
        reqData[8*i +: 8] = d;
        reqLast[i]       = l;
    endtask

    task automatic wait_rdy(input string tag, output int c);
        bit seen;
        seen = 1'b0;
        c = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (reqReady !== 4'b0000) begin
                seen = 1'b1;
                c = cyc;
            end
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        $display("[TB] cycle %0d %s: grant %0d byte %02h locked %0b", cyc, tag, grantId, txIn, locked);
    endtask

    task automatic wait_done(input string tag, output int c);
        bit seen;
        seen = 1'b0;
        c = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (txDone === 1'b1) begin
                seen = 1'b1;
                c = cyc;
            end
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_err(input string tag, output int c, output bit stray);
        bit seen;
        seen  = 1'b0;
        stray = 1'b0;
        c = 0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (reqReady !== 4'b0000) stray = 1'b1;
            if (errPulse === 1'b1) begin
                seen = 1'b1;
                c = cyc;
            end
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        $display("[TB] cycle %0d %s: errPulse locked %0b", cyc, tag, locked);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},  32'(reqReady), 32'd0);
        check({tag, "_grant"},  32'(grantId),  32'd0);
        check({tag, "_locked"}, 32'(locked),   32'd0);
        check({tag, "_err"},    32'(errPulse), 32'd0);
        check({tag, "_txen"},   32'(txEn),     32'd0);
        check({tag, "_start"},  32'(txStart),  32'd0);
        check({tag, "_txin"},   32'(txIn),     32'd0);
        check({tag, "_state"},  32'(dut.state_q), 32'(ST_IDLE));
    endtask

    initial begin
        int c0, c1, d, e, s;
        bit stray;

        rstN = 1'b0;
        reqValid = '0;
        reqData  = '0;
        reqLast  = '0;
        uart_mute = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rstN = 1'b1;
        @(negedge clk);
        check("rst_txen_after", 32'(txEn), 32'd1);
        check("rst_start_after", 32'(txStart), 32'd0);

        // Single requester 1, byte 56, then GAP measured by requester 0
        set_req(1, 1'b1, 8'h56, 1'b1);
        c0 = cyc;
        wait_rdy("t1_rdy", c1);
        check("t1_latency", 32'(c1 - c0), 32'd1);
        check("t1_ready", 32'(reqReady), 32'b0010);
        check("t1_txin", 32'(txIn), 32'h56);
        check("t1_start", 32'(txStart), 32'd1);
        check("t1_grant", 32'(grantId), 32'd1);
        check("t1_locked", 32'(locked), 32'd0);
        set_req(1, 1'b0, 8'h00, 1'b0);
        set_req(0, 1'b1, 8'h0F, 1'b1);
        @(negedge clk);
        check("t1_ready_pulse", 32'(reqReady), 32'd0);
        check("t1_start_pulse", 32'(txStart), 32'd0);
        wait_done("t1_done", d);
        check("t1_txin_held", 32'(txIn), 32'h56);
        wait_rdy("t1_next", c1);
        check("t1_gap", 32'(c1 - d), 32'd18);
        check("t1_next_ready", 32'(reqReady), 32'b0001);
        check("t1_next_txin", 32'(txIn), 32'h0F);
        set_req(0, 1'b0, 8'h00, 1'b0);
        wait_done("t1_done2", d);

        // All four valid after reset: order 0,1,2,3,0
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        for (int k = 0; k < 4; k++) set_req(k, 1'b1, 8'(8'hA0 + k), 1'b1);
        for (int n = 0; n < 5; n++) begin
            wait_rdy("t2_rdy", c1);
            check("t2_grant", 32'(grantId), 32'(n % 4));
            check("t2_ready", 32'(reqReady), 32'(1) << (n % 4));
            check("t2_txin", 32'(txIn), 32'(8'hA0 + (n % 4)));
        end

        // Requester 2 sends a 3-byte locked packet while 0 and 3 wait
        set_req(0, 1'b1, 8'hB0, 1'b1);
        set_req(1, 1'b0, 8'h00, 1'b0);
        set_req(2, 1'b1, 8'hC0, 1'b0);
        set_req(3, 1'b1, 8'hB3, 1'b1);
        wait_rdy("t3_b0", c1);
        check("t3_b0_grant", 32'(grantId), 32'd2);
        check("t3_b0_txin", 32'(txIn), 32'hC0);
        check("t3_b0_locked", 32'(locked), 32'd1);
        set_req(2, 1'b1, 8'hC1, 1'b0);
        wait_done("t3_d0", d);
        wait_rdy("t3_b1", c1);
        check("t3_b1_latency", 32'(c1 - d), 32'd2);
        check("t3_b1_start", 32'(txStart), 32'd1);
        check("t3_b1_grant", 32'(grantId), 32'd2);
        check("t3_b1_txin", 32'(txIn), 32'hC1);
        check("t3_b1_locked", 32'(locked), 32'd1);
        set_req(2, 1'b1, 8'hC2, 1'b1);
        wait_done("t3_d1", d);
        wait_rdy("t3_b2", c1);
        check("t3_b2_latency", 32'(c1 - d), 32'd2);
        check("t3_b2_grant", 32'(grantId), 32'd2);
        check("t3_b2_txin", 32'(txIn), 32'hC2);
        check("t3_b2_locked", 32'(locked), 32'd0);
        set_req(2, 1'b0, 8'h00, 1'b0);
        wait_rdy("t3_after", c1);
        check("t3_after_grant", 32'(grantId), 32'd3);
        check("t3_after_ready", 32'(reqReady), 32'b1000);
        check("t3_after_txin", 32'(txIn), 32'hB3);
        set_req(3, 1'b0, 8'h00, 1'b0);
        set_req(0, 1'b0, 8'h00, 1'b0);

        // txBusy never rises: busy timeout, then recovery to requester 2
        wait_done("t4_prev", d);
        uart_mute = 1'b1;
        set_req(1, 1'b1, 8'h11, 1'b1);
        wait_rdy("t4_rdy", s);
        check("t4_grant", 32'(grantId), 32'd1);
        check("t4_txin", 32'(txIn), 32'h11);
        set_req(1, 1'b0, 8'h00, 1'b0);
        set_req(2, 1'b1, 8'h22, 1'b1);
        wait_err("t4_err", e, stray);
        uart_mute = 1'b0;
        check("t4_err_delay", 32'(e - s), 32'd65);
        check("t4_err_locked", 32'(locked), 32'd0);
        check("t4_no_stray_grant", 32'(stray), 32'd0);
        wait_rdy("t4_recover", c1);
        check("t4_recover_delay", 32'(c1 - e), 32'd17);
        check("t4_recover_grant", 32'(grantId), 32'd2);
        check("t4_recover_txin", 32'(txIn), 32'h22);
        check("t4_err_pulse_width", 32'(errPulse), 32'd0);
        set_req(2, 1'b0, 8'h00, 1'b0);

        // Locked requester 0 goes silent: lock timeout after 100 cycles
        wait_done("t5_prev", d);
        set_req(0, 1'b1, 8'h5A, 1'b0);
        wait_rdy("t5_rdy", c1);
        check("t5_grant", 32'(grantId), 32'd0);
        check("t5_locked", 32'(locked), 32'd1);
        check("t5_txin", 32'(txIn), 32'h5A);
        set_req(0, 1'b0, 8'h00, 1'b0);
        set_req(3, 1'b1, 8'h33, 1'b1);
        wait_done("t5_done", d);
        wait_err("t5_err", e, stray);
        check("t5_err_delay", 32'(e - d), 32'd101);
        check("t5_err_locked", 32'(locked), 32'd0);
        check("t5_lock_blocks_others", 32'(stray), 32'd0);
        wait_rdy("t5_next", c1);
        check("t5_next_delay", 32'(c1 - e), 32'd1);
        check("t5_next_grant", 32'(grantId), 32'd3);
        check("t5_next_ready", 32'(reqReady), 32'b1000);
        check("t5_next_txin", 32'(txIn), 32'h33);
        check("t5_err_pulse_width", 32'(errPulse), 32'd0);
        set_req(3, 1'b0, 8'h00, 1'b0);

        // Reset during WAIT_DONE; the late txDone must be ignored
        repeat (2) @(negedge clk);
        check("t6_pre_state", 32'(dut.state_q), 32'(ST_WAIT_DONE));
        rstN = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        @(negedge clk);
        rstN = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_post_state", 32'(dut.state_q), 32'(ST_IDLE));
        check("t6_post_start", 32'(txStart), 32'd0);
        check("t6_post_err", 32'(errPulse), 32'd0);
        check("t6_post_txen", 32'(txEn), 32'd1);
        set_req(1, 1'b1, 8'h77, 1'b1);
        c0 = cyc;
        wait_rdy("t6_rdy", c1);
        check("t6_latency", 32'(c1 - c0), 32'd1);
        check("t6_grant", 32'(grantId), 32'd1);
        check("t6_ready", 32'(reqReady), 32'b0010);
        check("t6_txin", 32'(txIn), 32'h77);
        set_req(1, 1'b0, 8'h00, 1'b0);
        wait_done("t6_done", d);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single `Uart8` transmitter among `NUM_REQ` byte producers, such as the command echo, status reporter and debug dump. It sequences the UART tx handshake (`txStart` → `txBusy` → `txDone`) and supports locked multi-byte packets, so one requester's frame is never interleaved with another's. It sits between the requesters and the `txEn`/`txStart`/`txIn`/`txBusy`/`txDone` pins of `Uart8`.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `GAP_CYCLES`, 16: idle clk cycles inserted after each released packet before re-arbitration (0 allowed).
- `BUSY_TIMEOUT`, 64: max cycles to wait for `txBusy` after `txStart` before flagging an error.
- `LOCK_TIMEOUT`, 120000: max cycles a locked requester may leave `reqValid` low before its lock is dropped.
- `clk` in 1: system clock (12 MHz on Alhambra).
- `rstN` in 1: asynchronous, active-low reset.
- `reqValid` in NUM_REQ: requester i has a byte.
- `reqData` in 8*NUM_REQ: byte of requester i at bits [8i+7:8i].
- `reqLast` in NUM_REQ: byte is the last of its packet; 0 requests a lock.
- `reqReady` out NUM_REQ: one-cycle pulse, byte of requester i accepted.
- `grantId` out $clog2(NUM_REQ): current/last granted requester.
- `locked` out 1: a packet lock is held.
- `errPulse` out 1: one-cycle pulse on busy timeout or lock timeout.
- `txEn` out 1: UART tx enable.
- `txStart` out 1: start pulse to UART.
- `txIn` out 8: byte to UART, held stable from capture until `txDone`.
- `txBusy` in 1: UART transmitting.
- `txDone` in 1: UART finished a byte (one-cycle pulse).

## Operation
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; lock cleared.
- States: IDLE, START, WAIT_BUSY, WAIT_DONE, GAP. `txEn` is registered 1 in every state once out of reset.
- IDLE, unlocked:
  - Grant the first `reqValid` searching from `(grantId+1) mod NUM_REQ`, wrapping. On the first byte after reset the search starts at 0.
  - Capture `reqData` into `txIn`, pulse `reqReady[g]`, set `grantId`=g, set `locked`=!`reqLast[g]`, go to START.
- IDLE, locked:
  - Only `grantId` is eligible. Other requesters wait regardless of `reqValid`.
  - Lock counter increments while `reqValid[grantId]`=0. At `LOCK_TIMEOUT`: clear `locked`, pulse `errPulse`, stay in IDLE (arbitrate next cycle).
- START: `txStart`=1 for exactly one cycle, then WAIT_BUSY.
- WAIT_BUSY: on `txBusy`=1 go to WAIT_DONE. After `BUSY_TIMEOUT` cycles without it: pulse `errPulse`, clear `locked`, go to GAP. The byte is dropped and not retried.
- WAIT_DONE, on `txDone`:
  - If `locked`, go to IDLE with no gap, so the lock path continues back-to-back.
  - Otherwise go to GAP, or straight to IDLE if `GAP_CYCLES`=0.
- GAP: count `GAP_CYCLES`, then IDLE.
- A `txDone` seen outside WAIT_DONE is ignored.
- `reqLast`=1 on a locked requester's byte clears `locked` at capture.
- Counters are $clog2(max+1) wide, reset on every state entry, and saturate (no wrap).

## Timing
- Capture to `txStart`: 1 cycle. `reqReady` and `txIn` update in the capture cycle's register edge. `txStart` is high in the following cycle.
- `reqValid` low to high to `reqReady` in an idle system: 1 clk.
- Locked back-to-back bytes: `txDone` → IDLE (1) → capture (same IDLE cycle) → START, so 2 cycles from `txDone` to the next `txStart`.
- Requesters must hold `reqValid`/`reqData` until `reqReady`. Dropping `reqValid` earlier is legal (the request is withdrawn).
- Reset asserted mid-transfer: everything returns to reset values immediately. `Uart8` may finish its current byte, and that byte's `txDone` is ignored.

## Structure
- Shared package `uart_pkg`: state encoding, `UART_CLOCK_RATE`=12000000, default timeout constants.
- Sub-module `rr_picker`: combinational round-robin find-first from pointer over NUM_REQ, returning a valid flag and an index. It is the only natural split.

## Test plan
- Single requester 1, byte 8'h56, `reqLast`=1 → `reqReady[1]` pulse, `txIn`=8'h56, one `txStart`, GAP of 16 cycles after `txDone`.
- All four valid with 8'hA0..A3, `reqLast`=1 → grant order 0,1,2,3,0 with `txIn` matching each.
- Requester 2 sends 3-byte packet (`reqLast`=0,0,1) while 0 and 3 are valid → three bytes from 2 contiguous, `locked`=1 until the third capture, then 3 is granted.
- `txBusy` tied 0 → `errPulse` 65 cycles after `txStart`, arbiter recovers and serves the next requester.
- Locked requester drops `reqValid` (use `LOCK_TIMEOUT`=100 in this bench) → `errPulse` after 100 cycles, `locked`=0. Separately, assert `rstN`=0 in WAIT_DONE → all outputs 0 and state IDLE.
